aes_encrypt_ctrl: RTL and testbench

Iterative AES-128 encryption controller: accepts a 128-bit plaintext and key over a valid/ready handshake, then runs the initial AddRoundKey and 10 rounds, one round per clock. It sequences the shared encrypt datapath: AddRoundKey, SubBytes, ShiftRows and MixColumns. It also generates round keys on the fly, and returns the ciphertext over a second valid/ready handshake. It sits between the host/bus interface and the combinational round datapath.

---
 rtl/aes_encrypt_ctrl_if.sv | 24 ++
 rtl/aes_encrypt_ctrl.sv | 156 +++++++++++++++
 tb/tb_aes_encrypt_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/aes_encrypt_ctrl_if.sv
// Host-side bundle for the AES-128 encrypt controller: block in, ciphertext out, status.
// Latency: none, wires only.
// Backpressure: in_ready gates block acceptance; out_ready stalls the ciphertext output.
interface aes_encrypt_ctrl_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] plaintext;
   logic [127:0] key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] ciphertext;
   logic         busy;
   logic [3:0]   round;

   modport master (
      output in_valid, plaintext, key, out_ready,
      input  in_ready, out_valid, ciphertext, busy, round
   );

   modport slave (
      input  in_valid, plaintext, key, out_ready,
      output in_ready, out_valid, ciphertext, busy, round
   );
endinterface

// File: rtl/aes_encrypt_ctrl.sv
// Iterative AES-128 encryptor: one round per clock, round keys expanded on the fly.
// Latency: out_valid rises 10 cycles after the accept edge; one block per 11 cycles.
// Backpressure: ciphertext holds in DONE until out_ready; a new block may be taken on that edge.
module aes_encrypt_ctrl (
   input  logic                 clk,
   input  logic                 rst_n,
   aes_encrypt_ctrl_if.slave    bus
);

   typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

   fsm_e         fsm_q, fsm_d;
   logic [127:0] state_q, state_d;
   logic [127:0] rkey_q, rkey_d;
   logic [7:0]   rcon_q, rcon_d;
   logic [3:0]   round_q, round_d;
   logic         accept;
   logic [127:0] nk;
   logic [127:0] ss;
   logic [127:0] mc;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // S-box computed as GF(2^8) inverse (x^254, so 0 maps to 0) followed by the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] inv;
      logic [7:0] p;
      inv = 8'h01;
      p   = a;
      for (int i = 1; i < 8; i++) begin
         p   = gf_mul(p, p);
         inv = gf_mul(inv, p);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   // SubBytes and ShiftRows fused; byte i sits at [127-8i -: 8], row = i%4, column = i/4.
   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] o;
      int           src;
      o = '0;
      for (int i = 0; i < 16; i++) begin
         src = (i % 4) + 4 * (((i / 4) + (i % 4)) % 4);
         o[127-8*i -: 8] = sbox(s[127-8*src -: 8]);
      end
      return o;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   // Next round key; its four S-boxes are independent of the state datapath.
   function automatic logic [127:0] expand(input logic [127:0] rk, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3, rot, t, n0, n1, n2, n3;
      w0  = rk[127:96];
      w1  = rk[95:64];
      w2  = rk[63:32];
      w3  = rk[31:0];
      rot = {w3[23:0], w3[31:24]};
      t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
            ^ {rc, 24'h000000};
      n0  = w0 ^ t;
      n1  = w1 ^ n0;
      n2  = w2 ^ n1;
      n3  = w3 ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   assign bus.in_ready   = (fsm_q == IDLE) || ((fsm_q == DONE) && bus.out_ready);
   assign accept         = bus.in_valid && bus.in_ready;
   assign bus.out_valid  = (fsm_q == DONE);
   assign bus.ciphertext = (fsm_q == DONE) ? state_q : 128'h0;
   assign bus.busy       = (fsm_q == ROUND);
   assign bus.round      = (fsm_q == IDLE) ? 4'd0 : round_q;

   assign nk = expand(rkey_q, rcon_q);
   assign ss = sub_shift(state_q);
   assign mc = mix_columns(ss);

   // Next-state: load on accept (IDLE, or DONE with the output taken), else advance one round.
   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      rkey_d  = rkey_q;
      rcon_d  = rcon_q;
      round_d = round_q;
      if (accept) begin
         state_d = bus.plaintext ^ bus.key;
         rkey_d  = bus.key;
         rcon_d  = 8'h01;
         round_d = 4'd1;
         fsm_d   = ROUND;
      end else begin
         case (fsm_q)
            ROUND: begin
               state_d = ((round_q == 4'd10) ? ss : mc) ^ nk;
               rkey_d  = nk;
               rcon_d  = xtime(rcon_q);
               round_d = round_q + 4'd1;
               if (round_q == 4'd10) fsm_d = DONE;
            end
            DONE: begin
               if (bus.out_ready) fsm_d = IDLE;
            end
            default: ;
         endcase
      end
   end

   // State registers; async reset discards any block in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q   <= IDLE;
         state_q <= '0;
         rkey_q  <= '0;
         rcon_q  <= '0;
         round_q <= '0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         rkey_q  <= rkey_d;
         rcon_q  <= rcon_d;
         round_q <= round_d;
      end
   end

endmodule

// File: tb/tb_aes_encrypt_ctrl.sv
// Directed bench for aes_encrypt_ctrl using FIPS-197 vectors and a ciphertext scoreboard.
// Inputs change and outputs are sampled on the falling clock edge.
// Checks latency, back-to-back throughput, backpressure hold and asynchronous reset.
module tb_aes_encrypt_ctrl;

   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] ARK_B = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] RK10B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   logic [127:0] exp_q[$];

   aes_encrypt_ctrl_if bus();

   aes_encrypt_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Compare the visible ciphertext against the oldest expected entry.
   task automatic check_out(input string tag);
      logic [127:0] e;
      if (exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, 128'd0, 128'd1);
      end else begin
         e = exp_q.pop_front();
         check(tag, bus.ciphertext, e);
      end
   endtask

   // Step falling edges until out_valid, bounded; lat counts edges stepped.
   task automatic wait_valid(output int lat);
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic drive(input logic [127:0] pt, input logic [127:0] k);
      bus.in_valid  = 1'b1;
      bus.plaintext = pt;
      bus.key       = k;
   endtask

   initial begin
      int lat;
      int n;
      int seen;
      checks = 0;
      errors = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.plaintext = '0;
      bus.key       = '0;
      bus.out_ready = 1'b1;

      // Reset values
      #3;
      check("rst_in_ready", 128'(bus.in_ready), 128'd1);
      check("rst_out_valid", 128'(bus.out_valid), 128'd0);
      check("rst_busy", 128'(bus.busy), 128'd0);
      check("rst_round", 128'(bus.round), 128'd0);
      check("rst_ct", bus.ciphertext, 128'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // App. B: single block, latency, internal state checkpoints
      @(negedge clk);
      drive(PT_B, KEY_B);
      exp_q.push_back(CT_B);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("b_ark_state", dut.state_q, ARK_B);
      check("b_round1", 128'(bus.round), 128'd1);
      check("b_busy", 128'(bus.busy), 128'd1);
      check("b_in_ready_busy", 128'(bus.in_ready), 128'd0);
      wait_valid(lat);
      check("b_latency", 128'(lat), 128'd10);
      check("b_rkey10", dut.rkey_q, RK10B);
      check("b_round11", 128'(bus.round), 128'd11);
      check("b_in_ready_done", 128'(bus.in_ready), 128'd1);
      check_out("b_ct");
      @(negedge clk);
      check("b_idle_valid", 128'(bus.out_valid), 128'd0);
      check("b_idle_round", 128'(bus.round), 128'd0);

      // App. C.1
      drive(PT_C, KEY_C);
      exp_q.push_back(CT_C);
      @(negedge clk);
      bus.in_valid = 1'b0;
      wait_valid(lat);
      check("c_latency", 128'(lat), 128'd10);
      check_out("c_ct");
      @(negedge clk);

      // Back-to-back: C.1 then B with in_valid and out_ready held high
      drive(PT_C, KEY_C);
      exp_q.push_back(CT_C);
      @(negedge clk);
      drive(PT_B, KEY_B);
      exp_q.push_back(CT_B);
      wait_valid(lat);
      check("bb1_latency", 128'(lat), 128'd10);
      check_out("bb1_ct");
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("bb_gap_valid", 128'(bus.out_valid), 128'd0);
      check("bb_gap_round", 128'(bus.round), 128'd1);
      wait_valid(lat);
      check("bb_spacing", 128'(lat + 1), 128'd11);
      check_out("bb2_ct");
      @(negedge clk);
      check("bb_idle", 128'(bus.round), 128'd0);

      // Backpressure: out_ready low for 20 cycles after completion
      bus.out_ready = 1'b0;
      drive(PT_B, KEY_B);
      exp_q.push_back(CT_B);
      @(negedge clk);
      bus.in_valid = 1'b0;
      wait_valid(lat);
      check("bp_latency", 128'(lat), 128'd10);
      for (int i = 0; i < 20; i++) begin
         bus.in_valid  = i[0];
         bus.plaintext = {4{$urandom}};
         bus.key       = {4{$urandom}};
         @(negedge clk);
         check("bp_valid", 128'(bus.out_valid), 128'd1);
         check("bp_ct", bus.ciphertext, CT_B);
         check("bp_in_ready", 128'(bus.in_ready), 128'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      check_out("bp_release_ct");
      @(negedge clk);
      check("bp_after_valid", 128'(bus.out_valid), 128'd0);
      check("bp_after_busy", 128'(bus.busy), 128'd0);
      check("bp_after_round", 128'(bus.round), 128'd0);

      // Reset at round 5: block discarded, outputs drop immediately
      drive(PT_B, KEY_B);
      exp_q.push_back(CT_B);
      @(negedge clk);
      bus.in_valid = 1'b0;
      n = 0;
      while (bus.round != 4'd5 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("mr_reach_r5", 128'(bus.round), 128'd5);
      #1 rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("mr_in_ready", 128'(bus.in_ready), 128'd1);
      check("mr_busy", 128'(bus.busy), 128'd0);
      check("mr_round", 128'(bus.round), 128'd0);
      check("mr_out_valid", 128'(bus.out_valid), 128'd0);
      check("mr_state", dut.state_q, 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (bus.out_valid) seen++;
      end
      check("mr_no_output", 128'(seen), 128'd0);

      // Fresh App. B with inputs changed to all-ones right after accept
      drive(PT_B, KEY_B);
      exp_q.push_back(CT_B);
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.plaintext = '1;
      bus.key       = '1;
      wait_valid(lat);
      check("ic_latency", 128'(lat), 128'd10);
      check_out("ic_ct");
      @(negedge clk);
      check("sb_drained", 128'(exp_q.size()), 128'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
